// File: rtl/signed_add_arbiter.sv
// Round-robin arbiter in front of one shared signed W-bit adder.
// Results are registered behind a valid/ready handshake and tagged with the requester index.
module signed_add_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned W     = 4,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ*W-1:0]   req_a,
    input  logic [N_REQ*W-1:0]   req_b,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [ID_W-1:0]      res_id,
    output logic [W-1:0]         res_sum,
    output logic                 res_overflow,
    input  logic                 ovf_clear,
    output logic [7:0]           ovf_count
);

    localparam int unsigned CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [ID_W-1:0]  LAST_ID = ID_W'(N_REQ - 1);

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] ptr_nxt;
    logic            slot_free;
    logic            grant_any;
    logic [ID_W-1:0] grant_id;
    logic [ID_W-1:0] scan_idx;
    logic [W-1:0]    a_sel;
    logic [W-1:0]    b_sel;
    logic [W-1:0]    sum;
    logic            sum_ovf;

    assign slot_free = !res_valid || res_ready;

    // Scan from ptr upward (mod N_REQ); first valid requester wins. Grants are masked in reset.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        scan_idx  = '0;
        if (rst_n && slot_free) begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                scan_idx = ID_W'((32'(ptr) + k) % N_REQ);
                if (!grant_any && req_valid[scan_idx]) begin
                    grant_any = 1'b1;
                    grant_id  = scan_idx;
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_any) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // Operand mux for the winning requester
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if (grant_id == ID_W'(j)) begin
                a_sel = req_a[j*W +: W];
                b_sel = req_b[j*W +: W];
            end
        end
    end

    // Signed overflow: like-signed operands whose sum flips sign
    always_comb begin
        sum     = a_sel + b_sel;
        sum_ovf = (a_sel[W-1] == b_sel[W-1]) && (sum[W-1] != a_sel[W-1]);
    end

    assign ptr_nxt = (grant_id == LAST_ID) ? '0 : grant_id + ID_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (grant_any) begin
            ptr <= ptr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid    <= 1'b0;
            res_id       <= '0;
            res_sum      <= '0;
            res_overflow <= 1'b0;
        end else if (grant_any) begin
            res_valid    <= 1'b1;
            res_id       <= grant_id;
            res_sum      <= sum;
            res_overflow <= sum_ovf;
        end else if (res_ready) begin
            res_valid    <= 1'b0;
        end
    end

    // A clear coinciding with an overflowing grant still counts that grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count <= '0;
        end else if (grant_any && sum_ovf) begin
            if (ovf_clear) begin
                ovf_count <= CNT_W'(1);
            end else if (ovf_count != CNT_MAX) begin
                ovf_count <= ovf_count + CNT_W'(1);
            end
        end else if (ovf_clear) begin
            ovf_count <= '0;
        end
    end

endmodule

// File: tb/tb_signed_add_arbiter.sv
// Bench for signed_add_arbiter: directed scenarios with literal expectations,
// then constrained-random traffic, all cross-checked every cycle against a behavioural model.
module tb_signed_add_arbiter;

    localparam int N = 4;
    localparam int W = 4;
    localparam int IDW = 2;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic           res_valid;
    logic           res_ready;
    logic [IDW-1:0] res_id;
    logic [W-1:0]   res_sum;
    logic           res_overflow;
    logic           ovf_clear;
    logic [7:0]     ovf_count;

    int n_chk = 0;
    int n_err = 0;

    // behavioural model state
    int m_ptr = 0;
    bit m_valid = 0;
    int m_id = 0;
    int m_sum = 0;
    bit m_ovf = 0;
    int m_cnt = 0;
    logic [N-1:0] mg = '0;

    signed_add_arbiter #(.N_REQ(N), .W(W), .ID_W(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_sum(res_sum), .res_overflow(res_overflow),
        .ovf_clear(ovf_clear), .ovf_count(ovf_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_a[i*W +: W] = W'(a);
        req_b[i*W +: W] = W'(b);
    endtask

    // Model: compare outputs against current model state, then advance it for the coming edge
    always @(negedge clk) begin
        int g;
        int exp_ready;
        int sa;
        int sb;
        int full;
        bit ovf;
        logic signed [W-1:0] av;
        logic signed [W-1:0] bv;
        if (!rst_n) begin
            m_ptr = 0; m_valid = 0; m_id = 0; m_sum = 0; m_ovf = 0; m_cnt = 0; mg = '0;
            chk("rst_req_ready", int'(req_ready), 0);
            chk("rst_res_valid", int'(res_valid), 0);
            chk("rst_ovf_count", int'(ovf_count), 0);
        end else begin
            chk("m_res_valid", int'(res_valid), int'(m_valid));
            chk("m_res_id", int'(res_id), m_id);
            chk("m_res_sum", int'(res_sum), m_sum);
            chk("m_res_overflow", int'(res_overflow), int'(m_ovf));
            chk("m_ovf_count", int'(ovf_count), m_cnt);
            g = -1;
            if (!m_valid || res_ready) begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
                end
            end
            exp_ready = (g >= 0) ? (1 << g) : 0;
            chk("m_req_ready", int'(req_ready), exp_ready);
            mg = N'(exp_ready);
            if (g >= 0) begin
                av = req_a[g*W +: W];
                bv = req_b[g*W +: W];
                sa = int'(av);
                sb = int'(bv);
                full = sa + sb;
                ovf = (full > (1 << (W-1)) - 1) || (full < -(1 << (W-1)));
                m_valid = 1;
                m_id = g;
                m_sum = full & ((1 << W) - 1);
                m_ovf = ovf;
                m_ptr = (g + 1) % N;
                if (ovf) m_cnt = ovf_clear ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
                else if (ovf_clear) m_cnt = 0;
            end else begin
                if (res_ready) m_valid = 0;
                if (ovf_clear) m_cnt = 0;
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        req_valid = 4'b1111;
        req_a = '0;
        req_b = '0;
        res_ready = 1'b0;
        ovf_clear = 1'b0;
        #3;
        chk("reset_req_ready", int'(req_ready), 0);
        chk("reset_res_valid", int'(res_valid), 0);
        chk("reset_ovf_count", int'(ovf_count), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: single request, 3 + -5
        req_valid = 4'b0100;
        set_op(2, 3, -5);
        res_ready = 1'b1;
        #2 chk("t1_req_ready", int'(req_ready), 4'b0100);
        next_cycle();
        req_valid = '0;
        #2;
        chk("t1_res_valid", int'(res_valid), 1);
        chk("t1_res_id", int'(res_id), 2);
        chk("t1_res_sum", int'(res_sum), 4'hE);
        chk("t1_res_ovf", int'(res_overflow), 0);

        // 2: overflow cases on requester 0
        next_cycle();
        req_valid = 4'b0001;
        set_op(0, 4, 7);
        next_cycle();
        set_op(0, -4, -7);
        #2 chk("t2_sum0", int'(res_sum), 4'hB);
        chk("t2_ovf0", int'(res_overflow), 1);
        next_cycle();
        set_op(0, 4, -4);
        #2 chk("t2_sum1", int'(res_sum), 4'h5);
        chk("t2_ovf1", int'(res_overflow), 1);
        next_cycle();
        req_valid = '0;
        #2 chk("t2_sum2", int'(res_sum), 4'h0);
        chk("t2_ovf2", int'(res_overflow), 0);
        chk("t2_count", int'(ovf_count), 2);

        // 3: round-robin; park ptr at 0 via requester 3 first
        next_cycle();
        req_a = '0;
        req_b = '0;
        req_valid = 4'b1000;
        next_cycle();
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            #2 chk("t3_rr_grant", int'(req_ready), 1 << (k % 4));
            if (k > 0) chk("t3_rr_id", int'(res_id), (k - 1) % 4);
            next_cycle();
        end
        req_valid = 4'b1010;
        #2 chk("t3_pair_grant0", int'(req_ready), 4'b1000);
        next_cycle();
        #2 chk("t3_pair_grant1", int'(req_ready), 4'b0010);
        chk("t3_pair_id0", int'(res_id), 3);
        next_cycle();
        req_valid = '0;
        #2 chk("t3_pair_id1", int'(res_id), 1);

        // 4: backpressure
        next_cycle();
        req_valid = 4'b0001;
        set_op(0, 1, 2);
        #2 chk("t4_grant0", int'(req_ready), 4'b0001);
        next_cycle();
        req_valid = 4'b0010;
        set_op(1, 3, 4);
        res_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #2 chk("t4_bp_ready", int'(req_ready), 0);
            chk("t4_bp_valid", int'(res_valid), 1);
            chk("t4_bp_id", int'(res_id), 0);
            chk("t4_bp_sum", int'(res_sum), 3);
            next_cycle();
        end
        res_ready = 1'b1;
        #2 chk("t4_release_grant", int'(req_ready), 4'b0010);
        next_cycle();
        req_valid = '0;
        #2 chk("t4_after_valid", int'(res_valid), 1);
        chk("t4_after_id", int'(res_id), 1);
        chk("t4_after_sum", int'(res_sum), 7);

        // 5: saturation and clear
        next_cycle();
        for (int i = 0; i < N; i++) set_op(i, 7, 7);
        req_valid = 4'b1111;
        repeat (260) next_cycle();
        #2 chk("t5_saturated", int'(ovf_count), 255);
        ovf_clear = 1'b1;
        next_cycle();
        req_valid = '0;
        #2 chk("t5_clear_with_ovf", int'(ovf_count), 1);
        next_cycle();
        ovf_clear = 1'b0;
        #2 chk("t5_clear_alone", int'(ovf_count), 0);

        // 6: asynchronous reset with a pending result and ptr=3
        next_cycle();
        req_valid = 4'b0100;
        set_op(2, 7, 7);
        next_cycle();
        req_valid = '0;
        res_ready = 1'b0;
        chk("t6_pre_valid", int'(res_valid), 1);
        chk("t6_pre_count", int'(ovf_count), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_async_valid", int'(res_valid), 0);
        chk("t6_async_sum", int'(res_sum), 0);
        chk("t6_async_id", int'(res_id), 0);
        chk("t6_async_ovf", int'(res_overflow), 0);
        chk("t6_async_count", int'(ovf_count), 0);
        chk("t6_async_ready", int'(req_ready), 0);
        next_cycle();
        next_cycle();
        req_valid = 4'b1111;
        res_ready = 1'b1;
        rst_n = 1'b1;
        #2 chk("t6_first_grant", int'(req_ready), 4'b0001);
        next_cycle();
        #2 chk("t6_first_id", int'(res_id), 0);
        next_cycle();

        // random traffic; ungranted requesters hold their operands
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(req_valid[i] && !mg[i])) begin
                    if ($urandom_range(0, 9) < 6) begin
                        req_valid[i] = 1'b1;
                        req_a[i*W +: W] = W'($urandom);
                        req_b[i*W +: W] = W'($urandom);
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
            res_ready = ($urandom_range(0, 3) != 0);
            ovf_clear = ($urandom_range(0, 19) == 0);
            next_cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
